ulpi_reg_arbiter: RTL and testbench
===================================

Name: ulpi_reg_arbiter

Overview:
- Shares the ULPI register-access engines (register read and register write) between two requesters: the UART command path (requester 0) and the PHY init sequencer (requester 1).
- Performs round-robin arbitration, launches one PrR/PrW pulse per transaction and tracks the engine's busy flag.
- Returns read data or an error to the granted requester.
- Sits between the sniffer control logic and the ULPI register engines, in the clk_ULPI (60 MHz) domain.

Parameters:
- TIMEOUT_CYCLES, 64: clk_ULPI cycles allowed from issue until the engine releases busy before the transaction is aborted with err.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_ULPI  in  1  60 MHz ULPI clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; held high with fields stable until ack.
- we  in  2  per-requester access type: 1 = register write, 0 = register read.
- addr0, addr1  in  6 each  register address for requesters 0 and 1.
- wdata0, wdata1  in  8 each  write data for requesters 0 and 1.
- ack  out  2  one-cycle completion pulse to the granted requester.
- rdata  out  8  read result; valid while ack is high.
- err  out  1  high with ack when the transaction timed out.
- busy  out  1  high from grant to ack inclusive.
- DIR  in  1  ULPI DIR from the PHY; no grant while high.
- PrR  out  1  one-cycle start pulse to the register-read engine.
- PrW  out  1  one-cycle start pulse to the register-write engine.
- ADDR  out  6  address to the engines; held from ISSUE through ACK.
- REG_WDATA  out  8  write data to the write engine; held like ADDR.
- eng_busy  in  1  OR of the read and write engine busy flags.
- REG_VAL  in  8  read engine result.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; PrR, PrW, ack, err, busy = 0; ADDR, REG_WDATA, rdata = 0; priority pointer = 0; counter = 0.
- IDLE:
  - Leave IDLE only when req != 0 and DIR == 0.
  - Winner: if both requesters are requesting, the one selected by the pointer; otherwise the single requester.
  - Latch winner index, we, addr and wdata; set busy = 1; go to ISSUE.
  - While DIR == 1, stay in IDLE regardless of req.
- ISSUE (1 cycle):
  - Assert PrW if the latched we = 1, else PrR, for exactly one cycle.
  - ADDR/REG_WDATA already show the latched values in this cycle.
  - Clear the counter; go to WAIT_START.
- WAIT_START:
  - Counter increments each cycle.
  - eng_busy == 1: go to WAIT_DONE.
- WAIT_DONE:
  - Counter keeps incrementing.
  - eng_busy == 0: capture REG_VAL into rdata (reads) or 0 (writes); err = 0; go to ACK.
- Timeout:
  - In WAIT_START or WAIT_DONE, if the counter reaches TIMEOUT_CYCLES-1, go to ACK with err = 1 and rdata = 0.
  - Timeout takes precedence over an eng_busy change in the same cycle.
- ACK (1 cycle):
  - ack[winner] = 1; the other ack bit stays 0.
  - Pointer is set to the non-winner.
  - busy drops on the following edge; return to IDLE.
- Latency: uncontended grant → PrR/PrW pulse = 2 cycles after req is sampled high (IDLE then ISSUE).
- Requester rule: deassert req at the edge that samples ack.
  - The arbiter does not sample req during ISSUE, WAIT_START, WAIT_DONE or ACK.
  - A req still high in the next IDLE cycle is treated as a new request.
- DIR rising after the grant is ignored by the arbiter; the engines own bus turnaround.
- Changes to the losing requester's fields during a transaction have no effect; only latched values are used.
- Back-to-back: with both requesters continuously requesting, grants alternate 0, 1, 0, 1.
- Reset mid-transaction: immediate return to reset values. No ack is produced and no PrR/PrW pulse is emitted after release.
- Never more than one of PrR/PrW high. Never more than one ack bit high.

Decomposition:
- Shared package ulpi_pkg:
  - state encodings (IDLE, ISSUE, WAIT_START, WAIT_DONE, ACK);
  - requester index constants REQ_UART = 0, REQ_INIT = 1;
  - ULPI address width (6) and data width (8).
- One sub-module, ulpi_rr_pick:
  - combinational 2-way round-robin picker (req[1:0], ptr → grant index, valid);
  - pointer update stays in the arbiter.

Test Plan:
- Single read: req = 01, we = 0, addr0 = 0x16; engine busy 3 cycles, REG_VAL = 0xBA → PrR one cycle 2 cycles after req, ADDR = 0x16, ack = 01 with rdata = 0xBA, err = 0.
- Single write: req = 10, we = 2'b10, addr1 = 0x0A, wdata1 = 0x45 → PrW one cycle, ADDR = 0x0A, REG_WDATA = 0x45, ack = 10, rdata = 0x00.
- Contention: req = 11 held (each requester re-raises after ack), addr0 = 0x1F, addr1 = 0x1B → grant order 0, 1, 0, 1 with matching ADDR each transaction.
- DIR gating: DIR = 1 for 10 cycles with req = 01 → no PrR during DIR high; PrR 2 cycles after DIR falls.
- Timeout: eng_busy never asserts, TIMEOUT_CYCLES = 64 → ack = 01 with err = 1, rdata = 0; next request proceeds normally.
- Reset mid-operation: rst = 0 during WAIT_DONE → all outputs 0 immediately; after release, no ack or PrR/PrW until a new req.

Source files
------------

// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared types and constants for the ULPI register arbiter
package ulpi_pkg;

   localparam int ULPI_AW = 6;
   localparam int ULPI_DW = 8;

   localparam logic REQ_UART = 1'b0;
   localparam logic REQ_INIT = 1'b1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      ACK        = 3'd4
   } arb_state_e;

endpackage

// File: rtl/ulpi_rr_pick.sv
// rtl/ulpi_rr_pick.sv - combinational two-way round-robin picker
module ulpi_rr_pick (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic       grant_o,
   output logic       valid_o
);

   always_comb begin
      valid_o = |req_i;
      // Pointer only matters under contention; a lone requester always wins.
      if (&req_i) begin
         grant_o = ptr_i;
      end else begin
         grant_o = ~req_i[0];
      end
   end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// rtl/ulpi_reg_arbiter.sv - round-robin arbiter sharing the ULPI register
// read/write engines between the UART command path and the PHY init sequencer
module ulpi_reg_arbiter
   import ulpi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic               clk_ULPI,
   input  logic               rst,
   input  logic [1:0]         req,
   input  logic [1:0]         we,
   input  logic [ULPI_AW-1:0] addr0,
   input  logic [ULPI_AW-1:0] addr1,
   input  logic [ULPI_DW-1:0] wdata0,
   input  logic [ULPI_DW-1:0] wdata1,
   output logic [1:0]         ack,
   output logic [ULPI_DW-1:0] rdata,
   output logic               err,
   output logic               busy,
   input  logic               DIR,
   output logic               PrR,
   output logic               PrW,
   output logic [ULPI_AW-1:0] ADDR,
   output logic [ULPI_DW-1:0] REG_WDATA,
   input  logic               eng_busy,
   input  logic [ULPI_DW-1:0] REG_VAL
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e         state_q;
   logic               win_q;
   logic               we_q;
   logic               ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ULPI_AW-1:0] addr_q;
   logic [ULPI_DW-1:0] wdata_q;
   logic [ULPI_DW-1:0] rdata_q;
   logic [1:0]         ack_q;
   logic               err_q;
   logic               busy_q;
   logic               prr_q;
   logic               prw_q;

   logic pick_grant;
   logic pick_valid;

   ulpi_rr_pick u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .valid_o (pick_valid)
   );

   logic timeout;
   assign timeout = (cnt_q == CNT_LAST);

   always_ff @(posedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         win_q   <= REQ_UART;
         we_q    <= 1'b0;
         ptr_q   <= REQ_UART;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         prr_q   <= 1'b0;
         prw_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid && !DIR) begin
                  win_q   <= pick_grant;
                  we_q    <= we[pick_grant];
                  addr_q  <= pick_grant ? addr1 : addr0;
                  wdata_q <= pick_grant ? wdata1 : wdata0;
                  busy_q  <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               prw_q   <= we_q;
               prr_q   <= ~we_q;
               cnt_q   <= '0;
               state_q <= WAIT_START;
            end
            WAIT_START, WAIT_DONE: begin
               prr_q <= 1'b0;
               prw_q <= 1'b0;
               // Timeout wins over any engine busy edge seen in the same cycle.
               if (timeout) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  ack_q   <= win_q ? 2'b10 : 2'b01;
                  state_q <= ACK;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (state_q == WAIT_START) begin
                     if (eng_busy) begin
                        state_q <= WAIT_DONE;
                     end
                  end else if (!eng_busy) begin
                     rdata_q <= we_q ? '0 : REG_VAL;
                     err_q   <= 1'b0;
                     ack_q   <= win_q ? 2'b10 : 2'b01;
                     state_q <= ACK;
                  end
               end
            end
            ACK: begin
               ack_q   <= 2'b00;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               ptr_q   <= ~win_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign PrR       = prr_q;
   assign PrW       = prw_q;
   assign ADDR      = addr_q;
   assign REG_WDATA = wdata_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// tb/tb_ulpi_reg_arbiter.sv - scoreboard bench for the ULPI register arbiter
module tb_ulpi_reg_arbiter;

   logic       clk_ULPI = 1'b0;
   logic       rst      = 1'b0;
   logic [1:0] req      = 2'b00;
   logic [1:0] we       = 2'b00;
   logic [5:0] addr0    = '0;
   logic [5:0] addr1    = '0;
   logic [7:0] wdata0   = '0;
   logic [7:0] wdata1   = '0;
   logic       DIR      = 1'b0;
   logic [7:0] REG_VAL  = '0;
   logic       eng_busy;
   logic [1:0] ack;
   logic [7:0] rdata;
   logic       err;
   logic       busy;
   logic       PrR;
   logic       PrW;
   logic [5:0] ADDR;
   logic [7:0] REG_WDATA;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
   } iss_t;

   typedef struct {
      logic [1:0] ack;
      logic [7:0] rdata;
      logic       err;
   } ack_t;

   iss_t exp_iss[$];
   ack_t exp_ack[$];

   ulpi_reg_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
      .clk_ULPI  (clk_ULPI),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack       (ack),
      .rdata     (rdata),
      .err       (err),
      .busy      (busy),
      .DIR       (DIR),
      .PrR       (PrR),
      .PrW       (PrW),
      .ADDR      (ADDR),
      .REG_WDATA (REG_WDATA),
      .eng_busy  (eng_busy),
      .REG_VAL   (REG_VAL)
   );

   always #5 clk_ULPI = ~clk_ULPI;

   // Engine model: busy for eng_len cycles after a start pulse, if enabled.
   bit eng_en  = 1'b1;
   int eng_len = 3;
   int eng_cnt;
   always @(posedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         eng_busy <= 1'b0;
         eng_cnt  <= 0;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) eng_busy <= 1'b0;
      end else if ((PrR || PrW) && eng_en) begin
         eng_busy <= 1'b1;
         eng_cnt  <= eng_len;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pulse or an ack.
   always @(negedge clk_ULPI) begin
      if (rst) begin
         if (PrR || PrW) begin
            chk("pr_exclusive", {31'b0, PrR & PrW}, 32'd0);
            if (exp_iss.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_issue: PrR=%0b PrW=%0b ADDR=%0h", PrR, PrW, ADDR);
            end else begin
               iss_t e;
               e = exp_iss.pop_front();
               chk("issue_prw", {31'b0, PrW}, {31'b0, e.we});
               chk("issue_addr", {26'b0, ADDR}, {26'b0, e.addr});
               if (e.we) chk("issue_wdata", {24'b0, REG_WDATA}, {24'b0, e.wdata});
            end
         end
         if (ack != 2'b00) begin
            if (exp_ack.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: ack=%0b rdata=%0h err=%0b", ack, rdata, err);
            end else begin
               ack_t a;
               a = exp_ack.pop_front();
               chk("ack_bits", {30'b0, ack}, {30'b0, a.ack});
               chk("ack_rdata", {24'b0, rdata}, {24'b0, a.rdata});
               chk("ack_err", {31'b0, err}, {31'b0, a.err});
            end
         end
      end
   end

   task automatic expect_txn(input logic idx, input logic w, input logic [5:0] a,
                             input logic [7:0] wd, input logic [7:0] rd, input logic e);
      iss_t i;
      ack_t k;
      i.we = w; i.addr = a; i.wdata = wd;
      k.ack = idx ? 2'b10 : 2'b01; k.rdata = rd; k.err = e;
      exp_iss.push_back(i);
      exp_ack.push_back(k);
   endtask

   // Counts edges from now until a start pulse is seen.
   task automatic measure_pulse(output int n);
      n = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk_ULPI); #1;
         if (PrR || PrW) begin
            n = c;
            break;
         end
      end
   endtask

   // Waits for an ack, returns edges counted; drops req bits at the sampling edge.
   task automatic wait_ack(input string name, input logic [1:0] drop, output int n);
      n = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk_ULPI); #1;
         if (ack != 2'b00) begin
            n = c;
            break;
         end
      end
      if (n == 0) begin
         tests++;
         fails++;
         $display("FAIL %s_ack_timeout: no ack within 200 cycles", name);
      end
      @(posedge clk_ULPI); #1;
      req = req & ~drop;
   endtask

   initial begin
      int n;
      int acks;
      bit dir_bad;

      #22;
      chk("reset_outputs", {8'b0, PrR, PrW, ack, err, busy, ADDR, REG_WDATA, rdata}, 32'd0);
      @(negedge clk_ULPI); rst = 1'b1;
      repeat (3) @(posedge clk_ULPI);
      #1 chk("idle_busy", {31'b0, busy}, 32'd0);

      // Single read from the UART path.
      eng_len = 3; REG_VAL = 8'hBA; addr0 = 6'h16; we = 2'b00;
      expect_txn(1'b0, 1'b0, 6'h16, 8'h00, 8'hBA, 1'b0);
      req = 2'b01;
      measure_pulse(n);
      chk("read_latency", n, 32'd2);
      wait_ack("read", 2'b01, n);

      // Single write from the init sequencer.
      eng_len = 2; we = 2'b10; addr1 = 6'h0A; wdata1 = 8'h45;
      expect_txn(1'b1, 1'b1, 6'h0A, 8'h45, 8'h00, 1'b0);
      req = 2'b10;
      measure_pulse(n);
      chk("write_latency", n, 32'd2);
      wait_ack("write", 2'b10, n);

      // Contention: both held, grants must alternate starting at requester 0.
      eng_len = 2; we = 2'b00; addr0 = 6'h1F; addr1 = 6'h1B; REG_VAL = 8'h11;
      for (int t = 0; t < 4; t++) begin
         expect_txn(t[0], 1'b0, t[0] ? 6'h1B : 6'h1F, 8'h00, 8'h11, 1'b0);
      end
      req = 2'b11;
      acks = 0;
      for (int c = 0; c < 400 && acks < 4; c++) begin
         @(posedge clk_ULPI); #1;
         if (ack != 2'b00) acks++;
      end
      @(posedge clk_ULPI); #1;
      req = 2'b00;
      chk("contention_acks", acks, 32'd4);

      // DIR gating: no grant while the PHY owns the bus.
      REG_VAL = 8'h3C; addr0 = 6'h05; we = 2'b00;
      repeat (2) @(posedge clk_ULPI); #1;
      DIR = 1'b1;
      req = 2'b01;
      dir_bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_ULPI); #1;
         if (PrR || PrW || busy) dir_bad = 1'b1;
      end
      chk("dir_blocks_grant", {31'b0, dir_bad}, 32'd0);
      expect_txn(1'b0, 1'b0, 6'h05, 8'h00, 8'h3C, 1'b0);
      DIR = 1'b0;
      measure_pulse(n);
      chk("dir_release_latency", n, 32'd2);
      wait_ack("dir", 2'b01, n);

      // Timeout: engine never answers.
      eng_en = 1'b0; addr0 = 6'h2A; REG_VAL = 8'hEE;
      expect_txn(1'b0, 1'b0, 6'h2A, 8'h00, 8'h00, 1'b1);
      req = 2'b01;
      wait_ack("timeout", 2'b01, n);
      chk("timeout_cycles", n, 32'd66);
      eng_en = 1'b1;

      // Normal read after the timeout.
      eng_len = 3; addr1 = 6'h33; REG_VAL = 8'h77; we = 2'b00;
      expect_txn(1'b1, 1'b0, 6'h33, 8'h00, 8'h77, 1'b0);
      req = 2'b10;
      wait_ack("post_timeout", 2'b10, n);

      // Reset in the middle of WAIT_DONE.
      eng_len = 20; addr0 = 6'h12; REG_VAL = 8'h99;
      expect_txn(1'b0, 1'b0, 6'h12, 8'h00, 8'h99, 1'b0);
      req = 2'b01;
      for (int c = 0; c < 20 && !eng_busy; c++) @(posedge clk_ULPI);
      repeat (3) @(posedge clk_ULPI);
      chk("reset_mid_busy_before", {31'b0, busy}, 32'd1);
      #3;
      exp_ack.delete();
      rst = 1'b0;
      #1 chk("reset_mid_outputs", {8'b0, PrR, PrW, ack, err, busy, ADDR, REG_WDATA, rdata}, 32'd0);
      req = 2'b00;
      @(negedge clk_ULPI); rst = 1'b1;
      repeat (40) @(posedge clk_ULPI);
      #1 chk("after_reset_idle", {23'b0, busy, rdata}, 32'd0);

      chk("issue_queue_empty", exp_iss.size(), 32'd0);
      chk("ack_queue_empty", exp_ack.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
